// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter around the 3-bit 4:1 mux.
// Includes the state encoding and the rotating-priority pick function.
package mux_arb_pkg;

   localparam int N_REQ = 4;
   localparam int DW    = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Returns {found, idx}: the first set request at or after ptr, wrapping mod 4.
   // The loop runs from the farthest offset down, so the nearest offset wins.
   function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] req, input logic [1:0] ptr);
      logic [1:0] idx;
      logic [2:0] res;
      res = 3'b000;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = ptr + 2'(i);
         if (req[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4_1.sv
// Plain 3-bit 4:1 data multiplexer shared among the arbiter's requesters.
module mux4_1
   import mux_arb_pkg::*;
(
   input  logic [1:0]    s,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [DW-1:0] c,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] y
);

   always_comb begin
      y = a;
      case (s)
         2'd0: y = a;
         2'd1: y = b;
         2'd2: y = c;
         2'd3: y = d;
         default: y = a;
      endcase
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 mux, with a bounded
// grant length and a one-cycle preempt pulse when a grant is cut short.
module mux4_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int HOLD_MAX = 8,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic [DW-1:0]    a,
   input  logic [DW-1:0]    b,
   input  logic [DW-1:0]    c,
   input  logic [DW-1:0]    d,
   output logic [N_REQ-1:0] gnt,
   output logic [1:0]       s,
   output logic             valid,
   output logic [DW-1:0]    y,
   output logic             preempt
);

   state_t           state, state_n;
   logic [1:0]       ptr, ptr_n;
   logic [1:0]       s_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             expire;
   logic [2:0]       pick;
   logic [N_REQ-1:0] gnt_n;
   logic             valid_n;
   logic             preempt_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         ptr     <= 2'd0;
         s       <= 2'd0;
         cnt     <= '0;
         gnt     <= '0;
         valid   <= 1'b0;
         preempt <= 1'b0;
      end else begin
         state   <= state_n;
         ptr     <= ptr_n;
         s       <= s_n;
         cnt     <= cnt_n;
         gnt     <= gnt_n;
         valid   <= valid_n;
         preempt <= preempt_n;
      end
   end

   // Any release, voluntary or forced, passes through IDLE and advances ptr past the owner.
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      s_n     = s;
      cnt_n   = cnt;
      expire  = 1'b0;
      pick    = rr_pick(req, ptr);
      case (state)
         ST_IDLE: begin
            if (pick[2]) begin
               state_n = ST_BUSY;
               s_n     = pick[1:0];
               cnt_n   = CNT_W'(1);
            end
         end
         ST_BUSY: begin
            if (!req[s] || cnt == CNT_W'(HOLD_MAX)) begin
               state_n = ST_IDLE;
               ptr_n   = s + 2'd1;
               cnt_n   = '0;
               expire  = req[s];
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      gnt_n     = '0;
      valid_n   = (state_n == ST_BUSY);
      preempt_n = expire;
      if (state_n == ST_BUSY) gnt_n[s_n] = 1'b1;
   end

   mux4_1 u_mux (
      .s (s),
      .a (a),
      .b (b),
      .c (c),
      .d (d),
      .y (y)
   );

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares the 3-bit 4:1 data multiplexer (`mux4_1`) among four requesters. It owns the mux select: it grants one requester at a time, holds the grant while the requester keeps `req` high, and forces rotation after `HOLD_MAX` cycles. It sits between the four 3-bit sources and the single shared consumer, and qualifies the muxed data with `valid`.

## Interface
- `HOLD_MAX`, 8, maximum consecutive cycles one grant may last; legal range 1..(2^CNT_W − 1)
- `CNT_W`, 4, width of the hold counter
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  4  request per source; bit i ↔ source i (0=a, 1=b, 2=c, 3=d)
- `a`, `b`, `c`, `d`  in  3 each  source data
- `gnt`  out  4  one-hot grant, registered; all-zero when no owner
- `s`  out  2  mux select, registered; index of current/last owner
- `valid`  out  1  registered; 1 while `gnt` ≠ 0
- `y`  out  3  mux output (`a`/`b`/`c`/`d` selected by `s`), combinational from `s` and data
- `preempt`  out  1  registered one-cycle pulse when a grant is ended by `HOLD_MAX`

## Operation
- Two states: IDLE (no owner) and BUSY (owner = `s`).
- Rotation pointer `ptr` (2 bits): search order ptr, ptr+1, ptr+2, ptr+3, mod 4; first set `req` bit wins.
- IDLE: if any `req`, then at the next edge go to BUSY with `gnt` = one-hot(winner), `s` = winner, `valid` = 1, `cnt` = 1. Otherwise stay in IDLE and hold `s`.
- BUSY, at each edge:
  - If `req[s]` = 0, release.
  - Else if `cnt` = HOLD_MAX, release and pulse `preempt` = 1 for one cycle.
  - Else `cnt` += 1 and stay in BUSY.
- Release: next state is IDLE, `gnt` = 0, `valid` = 0, `ptr` = s+1 (wraps 3→0), `s` unchanged.
- A request dropping in the same cycle that `cnt` = HOLD_MAX is a normal release: `preempt` stays 0.
- A preempted requester that keeps `req` high is re-eligible. It is served after the other active requesters. If it is the only requester, it is re-granted after one IDLE cycle.
- `req` changes on non-owners during BUSY have no effect until the next IDLE cycle.
- `y` is only meaningful while `valid` = 1. It is not gated otherwise.

## Timing
- Reset values: state IDLE, `gnt` = 0000, `s` = 00, `valid` = 0, `preempt` = 0, `ptr` = 0, `cnt` = 0. Consequently `y` = `a`.
- Latency from request to grant: a `req` sampled in IDLE at edge k produces `gnt` and `valid` valid after edge k.
- Grant length:
  - A grant lasts min(HOLD_MAX, cycles until `req` drops) cycles of `valid` = 1.
  - The owner's `req` low sampled at edge k clears `gnt` after edge k.
- Every release is followed by exactly one IDLE cycle, so back-to-back owners are separated by one `valid` = 0 cycle.
- `preempt` is high for exactly the IDLE cycle after a forced release.
- Reset during BUSY: at the next edge all registers return to their reset values, and `ptr` restarts at 0.
- HOLD_MAX = 1: every grant is one cycle. `preempt` fires when `req` is still high.

## Structure
- Shared package `mux_arb_pkg` holds:
  - `N_REQ` = 4 and `DW` = 3
  - state encodings `ST_IDLE` = 0, `ST_BUSY` = 1
  - function `rr_pick(req, ptr)`, which returns {found, idx}
- Sub-module: one `mux4_1` instance driven by registered `s`, producing `y`. No other hierarchy.

## Test plan
- **Single requester.** After reset, `req` = 0010 for 3 cycles then 0000.
  - Required: `gnt` = 0010, `s` = 01, `valid` = 1 for 3 cycles, `y` = `b`, `preempt` = 0.
  - Then one IDLE cycle, `ptr` = 2.
- **Round robin.** `req` = 1111 held, each owner dropping its bit after 2 cycles and reasserting it.
  - Required grant order 0,1,2,3,0. Each grant lasts 2 cycles, with one `valid` = 0 cycle between grants.
- **Preemption.** HOLD_MAX = 8, `req` = 0001 held for 20 cycles.
  - Required: `valid` high for 8 cycles, then `preempt` = 1 with `valid` = 0 for one cycle, then a re-grant to 0.
  - Same stimulus with `req` = 0101: the grant moves to 2 after the preempt.
- **Pointer wrap.** Owner 3 releases with `req` = 1001 pending.
  - Required: the next grant goes to 0 (`s` = 00), not 3.
- **Simultaneous drop and expiry.** The owner's `req` falls in the cycle where `cnt` = HOLD_MAX.
  - Required: release with `preempt` = 0.
- **Reset mid-grant.** Assert `rst` for one cycle during BUSY with owner 2.
  - Required after the edge: `gnt` = 0, `s` = 0, `valid` = 0, `preempt` = 0.
  - With `req` = 0100 held, 2 is re-granted on the edge after `rst` falls.
